// File: rtl/uart_word_loader.sv
// UART (8N1) receiver that packs little-endian bytes into 32-bit words in a DEPTH-entry buffer.
// Define UART_LOADER_ECHO_EN to re-transmit every received byte on tx.
module uart_word_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              rx,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              load_done,
  output logic              frame_err,
  output logic              overflow,
  output logic              tx
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CNT_W   = $clog2(BIT_DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        r_rx_state, w_rx_next;
  logic             r_rx_meta, r_rx_sync;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_zero, w_byte_valid, w_frame_bad;

  logic [31:0]      r_buf [DEPTH];
  logic [23:0]      r_asm;
  logic [1:0]       r_lane;
  logic [ADDR_W:0]  r_word_count;
  logic             r_load_done, r_frame_err, r_overflow;
  logic [31:0]      r_rd_data;
  logic             w_full;

  assign w_rx_zero = (r_rx_cnt == '0);
  assign w_full    = (r_word_count == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_byte_valid = 1'b0;
    w_frame_bad  = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_rx_zero) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_zero && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_rx_zero) begin
          w_rx_next    = RX_IDLE;
          w_byte_valid = r_rx_sync;
          w_frame_bad  = !r_rx_sync;
        end
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE:  r_rx_cnt <= HALF_LAST;
        RX_START: begin
          r_rx_bit <= '0;
          r_rx_cnt <= w_rx_zero ? BIT_LAST : r_rx_cnt - 1'b1;
        end
        RX_DATA: begin
          if (w_rx_zero) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            r_rx_cnt   <= BIT_LAST;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_STOP:  if (!w_rx_zero) r_rx_cnt <= r_rx_cnt - 1'b1;
        default:  r_rx_cnt <= '0;
      endcase
    end
  end

  // clr has priority over a byte completing in the same cycle; the buffer survives clr.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_asm        <= '0;
      r_lane       <= '0;
      r_word_count <= '0;
      r_load_done  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_rd_data <= r_buf[rd_addr];
      if (clr) begin
        r_lane       <= '0;
        r_word_count <= '0;
        r_load_done  <= 1'b0;
        r_frame_err  <= 1'b0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_frame_bad) r_frame_err <= 1'b1;
        if (w_byte_valid) begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            case (r_lane)
              2'd0: r_asm[7:0]   <= r_rx_shift;
              2'd1: r_asm[15:8]  <= r_rx_shift;
              2'd2: r_asm[23:16] <= r_rx_shift;
              default: begin
                r_buf[r_word_count[ADDR_W-1:0]] <= {r_rx_shift, r_asm};
                r_word_count <= r_word_count + 1'b1;
                if (r_word_count == (ADDR_W+1)'(DEPTH - 1)) r_load_done <= 1'b1;
              end
            endcase
            r_lane <= r_lane + 2'd1;
          end
        end
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign word_count = r_word_count;
  assign full       = w_full;
  assign load_done  = r_load_done;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

`ifdef UART_LOADER_ECHO_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        r_tx_state, w_tx_next;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_pend_valid;
  logic [7:0]       r_pend_data;
  logic             r_tx;
  logic             w_tx_zero, w_tx_load;

  assign w_tx_zero = (r_tx_cnt == '0);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_pend_valid) begin
          w_tx_next = TX_START;
          w_tx_load = 1'b1;
        end
      end
      TX_START: if (w_tx_zero) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_zero && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_zero) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // A new byte always lands in the pending slot, even when the old one is being taken.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_tx_state   <= TX_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_tx_shift   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_tx         <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_byte_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= r_rx_shift;
      end else if (w_tx_load) begin
        r_pend_valid <= 1'b0;
      end
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_load) begin
            r_tx_shift <= r_pend_data;
            r_tx_cnt   <= BIT_LAST;
            r_tx_bit   <= '0;
            r_tx       <= 1'b0;
          end else begin
            r_tx <= 1'b1;
          end
        end
        TX_START: begin
          if (w_tx_zero) begin
            r_tx_cnt <= BIT_LAST;
            r_tx     <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_zero) begin
            r_tx_cnt <= BIT_LAST;
            if (r_tx_bit == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_STOP:  if (!w_tx_zero) r_tx_cnt <= r_tx_cnt - 1'b1;
        default:  r_tx <= 1'b1;
      endcase
    end
  end

  assign tx = r_tx;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
Upstream feeder for the commit-stage request sequencer. It receives a UART byte stream (8N1) and assembles little-endian 32-bit words. It stores them in a DEPTH-entry word buffer that the top-level sequencer reads by address, one word per request.
It also reports fill status, a load-complete flag and error flags. With the echo option compiled in, it re-transmits received bytes on tx for host-side confirmation.

Parameters:
CLK_HZ, 50000000, clk frequency in Hz
BAUD, 115200, UART bit rate
DEPTH, 16, number of 32-bit words in buffer (power of 2)
ADDR_W, 4, log2(DEPTH)

Ports:
clk  in  1  system clock
reset_in  in  1  asynchronous reset, active-low
rx  in  1  UART serial input, idle high, asynchronous to clk
clr  in  1  synchronous pulse; restarts loading (pointer, byte lane, flags)
rd_addr  in  ADDR_W  buffer read address
rd_data  out  32  word at rd_addr, registered
word_count  out  ADDR_W+1  number of complete words written since reset/clr
full  out  1  word_count == DEPTH
load_done  out  1  sticky; set when buffer becomes full
frame_err  out  1  sticky; stop bit sampled low
overflow  out  1  sticky; valid byte received while full
tx  out  1  UART serial output (echo), idle high

Behaviour:
- Reset values (reset_in low): all outputs 0 except tx=1; buffer contents 0; RX FSM IDLE; byte lane 0; write pointer 0.
- BIT_DIV = CLK_HZ/BAUD (integer truncation); HALF = BIT_DIV/2. Default values: 434 and 217.
- rx passes through a 2-FF synchroniser; the FSM uses only the synchronised value.
- RX FSM states:
  - IDLE: on synchronised rx==0, load counter and go to START.
  - START: after HALF cycles, re-sample. If rx==1 it is a glitch: return to IDLE with no flag. If rx==0, go to DATA.
  - DATA: sample every BIT_DIV cycles, 8 bits, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: after BIT_DIV cycles, sample. If 1, raise byte_valid for 1 cycle. If 0, set frame_err and discard the byte. Return to IDLE in both cases.
- Assembly: a valid byte is written into lane L (0..3) of the assembly register, with lane 0 = bits [7:0]; then L increments.
- Word commit: on the 4th byte (L==3), the word {byte3,byte2,byte1,byte0} is written to buffer[wr_ptr] in the same cycle as byte_valid. Then wr_ptr increments, word_count increments and L returns to 0.
- Fill boundary: when word_count reaches DEPTH, full=1 and load_done=1 on the next cycle. wr_ptr does not wrap.
- While full, valid bytes are dropped and set overflow. The lane does not advance and the buffer is unchanged.
- Read: rd_data <= buffer[rd_addr] every clk cycle; latency 1 cycle. Addresses not yet written return the reset value 0 or the previous contents.
- Write and read to the same address in the same cycle return the old data (read-before-write).
- clr: zeros wr_ptr, L, word_count, full, load_done, frame_err and overflow. Buffer contents are kept.
  - The RX FSM is not reset, so a byte in flight completes and is counted as lane 0.
  - If clr coincides with byte_valid, clr wins and the byte is discarded.
- Reset mid-frame: everything returns to the reset values. The remainder of the frame is parsed from IDLE, so a low data bit may start a false frame; the host must idle ≥1 frame after reset.
- A partial word (L≠0) is never visible in word_count or the buffer.

Optional Feature:
Macro UART_LOADER_ECHO_EN.
- Defined: TX FSM with states IDLE, START, DATA, STOP at BIT_DIV per bit.
  - Every valid byte, including bytes dropped while full, is placed into a 1-entry pending register. The TX FSM sends it when idle.
  - If a byte arrives while one is already pending, the new byte overwrites the pending one.
  - tx=1 when idle.
- Undefined: no TX logic; tx is held at constant 1.

Test Plan:
- Send bytes 0x78,0x56,0x34,0x12 -> word_count 0→1 on the cycle after the 4th stop bit. Then rd_addr=0 gives rd_data=0x12345678 one cycle later.
- Send 64 bytes (16 words, byte k = k) -> full=1, load_done=1, word_count=16. buffer[15]=0x3F3E3D3C. A 65th byte sets overflow=1 and leaves buffer[0]=0x03020100.
- Frame with stop bit forced 0, then bytes 0xAA,0xBB,0xCC,0xDD -> frame_err=1. The bad byte is excluded and word 0 = 0xDDCCBBAA.
- rx low pulse of 100 cycles (< HALF) -> no byte, no flags, FSM back in IDLE.
- Load 2 words, send 2 bytes of a 3rd, pulse clr, send 4 bytes 0x01..0x04 -> word_count=1, buffer[0]=0x04030201, all flags 0.
- With UART_LOADER_ECHO_EN: send 0x5A -> tx shows start bit, 0x5A LSB-first and a stop bit, each BIT_DIV wide. Without the macro, tx stays 1 throughout.
